gyro_rx_packetizer: RTL
=======================

// Module: gyro_rx_packetizer
// PURPOSE
//  Downstream of the bidirectional serializer's RX FIFO read side (clock domain).
//  Accepts 48-bit gyro samples over a valid/ready stream.
//  Packs each sample pair into three 32-bit words for the AXI-Stream DMA path.
//  Frames packets of 64<<packet_sel samples, asserting m_tlast on the final word.
//  Supplies the packet framing the serializer's RX side does not (its last is tied 0).
// PARAMETERS
//  SAMPLE_W   48   input sample width; fixed, packing below assumes 48
//  OUT_W      32   output word width; fixed
//  PCNT_W     16   width of completed-packet counter
// PORTS
//  clock         in   1        system clock (same clock as serializer rx_fifo read side)
//  reset         in   1        synchronous, active-high reset
//  in_start_stop in   1        1 = framing enabled; 0 = stop at next packet boundary
//  packet_sel    in   3        packet length = 64<<packet_sel samples (64..8192)
//  s_tdata       in   48       sample from rx FIFO
//  s_tvalid      in   1        sample valid
//  s_tready      out  1        sample accepted when s_tvalid & s_tready
//  m_tdata       out  32       packed output word
//  m_tvalid      out  1        output word valid
//  m_tready      in   1        downstream ready
//  m_tlast       out  1        last word of packet
//  packet_count  out  PCNT_W   completed packets since reset, wraps
//  busy          out  1        state != IDLE
// BEHAVIOUR
//  Reset values:
//  - state = IDLE; all outputs 0.
//  - hold_a, hold_b, pair_cnt and len_sel are cleared.
//  Packing: sample A then sample B produce, in order:
//  - w0 = A[31:0]
//  - w1 = {B[15:0], A[47:32]}
//  - w2 = B[47:16]
//  FSM: one transition per clock.
//  - IDLE:  if in_start_stop, latch len_sel <= packet_sel, clear pair_cnt, go GET_A.
//  - GET_A: s_tready = 1; on handshake hold_a <= s_tdata, go W0.
//  - W0:    m_tvalid = 1, m_tdata = w0; on m_tready go GET_B.
//  - GET_B: s_tready = 1; on handshake hold_b <= s_tdata, go W1.
//  - W1:    m_tvalid = 1, m_tdata = w1; on m_tready go W2.
//  - W2:    m_tvalid = 1, m_tdata = w2; m_tlast = (pair_cnt == (32<<len_sel) - 1).
//           On m_tready, if not last: pair_cnt++ and go GET_A.
//           On m_tready, if last: packet_count++, pair_cnt <= 0.
//           After last: go GET_A if in_start_stop (relatch len_sel <= packet_sel), else IDLE.
//  Handshakes and outputs:
//  - s_tready is 0 outside GET_A and GET_B.
//  - m_tvalid is 0 outside W0, W1 and W2.
//  - m_tdata and m_tlast are driven from hold registers only.
//  - They are stable while m_tvalid & !m_tready (AXI rule).
//  - m_tvalid never drops without a handshake.
//  Latency and throughput:
//  - Latency: 1 clock from sample-A accept to w0 valid.
//  - Peak rate: 3 words per 5 clocks. This exceeds the serializer's 48-clock-per-sample input rate.
//  Widths:
//  - pair_cnt is 12 bits; max value is 4095 at sel = 7.
//  - 32<<len_sel is evaluated at 13 bits.
//  Boundary conditions:
//  - in_start_stop falls mid-packet: the packet completes in full, never truncated.
//    Then IDLE, and s_tready = 0 from that point on.
//  - packet_sel changes mid-packet: ignored until the next packet start.
//  - s_tvalid low in GET states: wait indefinitely, no timeout, no padding.
//  - reset asserted mid-packet: the partial packet is discarded, with no tlast and no count.
//    Next packet starts fresh at w0.
//  - packet_count wraps from 0xFFFF to 0.
// TESTING
//  1. A=48'h111122223333, B=48'h444455556666
//     -> words 32'h22223333, 32'h66661111, 32'h44445555.
//  2. sel=0, 64 incrementing samples, m_tready=1
//     -> 96 words, m_tlast only on word 95, packet_count=1.
//  3. sel=1, m_tready random 50%
//     -> 192 words in order, data stable under stall, no drop or dup.
//  4. in_start_stop drops after sample 10, sel=0
//     -> packet finishes at 64 samples with tlast; then busy=0, s_tready=0.
//  5. packet_sel 0->2 during packet 1
//     -> packet 1 = 96 words, packet 2 = 384 words.
//  6. reset after sample 20
//     -> m_tvalid=0, packet_count=0; following 64 samples yield one clean 96-word packet.

Source files
------------

// File: rtl/gyro_rx_packetizer.sv
// Packs pairs of 48-bit gyro samples into three 32-bit AXI-Stream words and
// frames packets of 64<<packet_sel samples, marking the final word with m_tlast.
module gyro_rx_packetizer #(
  parameter int SAMPLE_W = 48,
  parameter int OUT_W    = 32,
  parameter int PCNT_W   = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_start_stop,
  input  logic [2:0]          packet_sel,
  input  logic [SAMPLE_W-1:0] s_tdata,
  input  logic                s_tvalid,
  output logic                s_tready,
  output logic [OUT_W-1:0]    m_tdata,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic                m_tlast,
  output logic [PCNT_W-1:0]   packet_count,
  output logic                busy,
  output logic [2:0]          dbg_state
);

  // Handshake rule on both sides: a transfer happens on the rising clock edge
  // where valid and ready are both high; a raised m_tvalid holds its word
  // unchanged until that edge.
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] GET_A = 3'd1;
  localparam logic [2:0] W0    = 3'd2;
  localparam logic [2:0] GET_B = 3'd3;
  localparam logic [2:0] W1    = 3'd4;
  localparam logic [2:0] W2    = 3'd5;

  logic [2:0]          state_q, state_d;
  logic [SAMPLE_W-1:0] hold_a_q, hold_a_d;
  logic [SAMPLE_W-1:0] hold_b_q, hold_b_d;
  logic [11:0]         pair_cnt_q, pair_cnt_d;
  logic [2:0]          len_sel_q, len_sel_d;
  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;

  logic [12:0] last_pair;
  logic        is_last;

  // Pairs per packet is 32<<len_sel; needs 13 bits to hold 4096 at sel = 7.
  assign last_pair = (13'd32 << len_sel_q) - 13'd1;
  assign is_last   = ({1'b0, pair_cnt_q} == last_pair);

  assign s_tready     = (state_q == GET_A) || (state_q == GET_B);
  assign m_tvalid     = (state_q == W0) || (state_q == W1) || (state_q == W2);
  assign m_tlast      = (state_q == W2) && is_last;
  assign packet_count = pcnt_q;
  assign busy         = (state_q != IDLE);
  assign dbg_state    = state_q;

  always_comb begin
    m_tdata = '0;
    case (state_q)
      W0:      m_tdata = hold_a_q[31:0];
      W1:      m_tdata = {hold_b_q[15:0], hold_a_q[47:32]};
      W2:      m_tdata = hold_b_q[47:16];
      default: m_tdata = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    hold_a_d   = hold_a_q;
    hold_b_d   = hold_b_q;
    pair_cnt_d = pair_cnt_q;
    len_sel_d  = len_sel_q;
    pcnt_d     = pcnt_q;
    case (state_q)
      IDLE: begin
        if (in_start_stop) begin
          len_sel_d  = packet_sel;
          pair_cnt_d = '0;
          state_d    = GET_A;
        end
      end
      GET_A: begin
        if (s_tvalid) begin
          hold_a_d = s_tdata;
          state_d  = W0;
        end
      end
      W0: if (m_tready) state_d = GET_B;
      GET_B: begin
        if (s_tvalid) begin
          hold_b_d = s_tdata;
          state_d  = W1;
        end
      end
      W1: if (m_tready) state_d = W2;
      W2: begin
        if (m_tready) begin
          if (!is_last) begin
            pair_cnt_d = pair_cnt_q + 12'd1;
            state_d    = GET_A;
          end else begin
            // Stop requests only take effect here, so packets are never truncated.
            pcnt_d     = pcnt_q + 1'b1;
            pair_cnt_d = '0;
            if (in_start_stop) begin
              len_sel_d = packet_sel;
              state_d   = GET_A;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      hold_a_q   <= '0;
      hold_b_q   <= '0;
      pair_cnt_q <= '0;
      len_sel_q  <= '0;
      pcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      hold_a_q   <= hold_a_d;
      hold_b_q   <= hold_b_d;
      pair_cnt_q <= pair_cnt_d;
      len_sel_q  <= len_sel_d;
      pcnt_q     <= pcnt_d;
    end
  end

endmodule
